// File: rtl/mem_pkg.sv
// Shared types and default sizing for the processor data memory bank.
package mem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 256;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage with per-byte write enables and a registered read port.
// Storage is never reset; only the read register has a reset value.
module mem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [BE_W-1:0]   wbe,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;

    assign widx = waddr[IDX_W-1:0];
    assign ridx = raddr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wbe[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Out-of-range reads load zero instead of indexing storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[ridx];
        end
    end

endmodule

// File: rtl/sync_mem_bank.sv
// Data memory bank: ready/valid request port, byte-enable writes, one-cycle
// reads, and a zero-fill sequencer that runs after reset and soft clear.
module sync_mem_bank
    import mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [be_width(DATA_W)-1:0] req_be,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        init_done
);

    localparam int unsigned BE_W = be_width(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              done_d;
    logic              accept;
    logic              in_range;
    logic              rd_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_wbe;

    assign in_range = 32'(req_addr) < DEPTH;

    // Next state, handshake and write-port mux (fill vs. request).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = init_done;
        req_ready = 1'b0;
        accept    = 1'b0;
        rd_en     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        mem_wbe   = req_be;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = INIT_VAL;
                mem_wbe   = '1;
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                req_ready = !clr;
                accept    = req_valid && !clr;
                mem_we    = accept && req_we && in_range;
                rd_en     = accept && !req_we;
                if (clr) begin
                    state_d = ST_INIT;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_done <= done_d;
            rsp_valid <= rd_en;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BE_W   (BE_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .wbe   (mem_wbe),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_en),
        .rzero (!in_range),
        .raddr (req_addr),
        .rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_sync_mem_bank.sv
// Scoreboard bench for sync_mem_bank: a full-depth bank and a DEPTH=200 bank
// share one stimulus stream and are checked against a behavioural model.
module tb_sync_mem_bank;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned BW = 2;
    localparam int unsigned D0 = 256;
    localparam int unsigned D1 = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be = '0;
    logic [1:0]    rdy;
    logic [1:0]    rv;
    logic [1:0]    done;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;

    int tests = 0;
    int fails = 0;

    // Behavioural model: per bank, running flag, fill cycles left, contents.
    bit            run [2];
    int            fill_left [2];
    logic [DW-1:0] mmem [2][256];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] last [2];

    always #5 clk = ~clk;

    sync_mem_bank u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[0]), .rsp_rdata(rd0), .init_done(done[0])
    );

    sync_mem_bank #(.DEPTH(D1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[1]), .rsp_rdata(rd1), .init_done(done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 0) ? int'(D0) : int'(D1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            run[i]       = 1'b0;
            fill_left[i] = depth_of(i);
        end
        q0.delete();
        q1.delete();
    endtask

    // Apply one cycle of the bank's rules to bank i for the given request.
    task automatic model_cycle(input int i, input bit v, input bit we, input int a,
                               input logic [DW-1:0] d, input logic [BW-1:0] be, input bit c);
        logic [DW-1:0] e;
        if (!run[i]) begin
            if (c) begin
                fill_left[i] = depth_of(i);
            end else begin
                fill_left[i]--;
                if (fill_left[i] == 0) begin
                    run[i] = 1'b1;
                    for (int k = 0; k < 256; k++) mmem[i][k] = '0;
                end
            end
        end else if (c) begin
            run[i]       = 1'b0;
            fill_left[i] = depth_of(i);
        end else if (v) begin
            if (we) begin
                if (a < depth_of(i)) begin
                    for (int b = 0; b < int'(BW); b++)
                        if (be[b]) mmem[i][a][b*8 +: 8] = d[b*8 +: 8];
                end
            end else begin
                e = (a < depth_of(i)) ? mmem[i][a] : '0;
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // Drive one cycle (called just after a rising edge), check handshake, advance.
    task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be, input bit c);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        clr       = c;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("req_ready", 32'(rdy[i]), 32'(run[i] && !c));
            check("init_done", 32'(done[i]), 32'(run[i]));
            model_cycle(i, v, we, int'(a), d, be, c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b1, 1'b0, a, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        step(1'b1, 1'b1, a, d, be, 1'b0);
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (!(run[0] && run[1]) && n < 600) begin
            idle();
            n++;
        end
        check(name, 32'(n < 600), 32'd1);
    endtask

    // Monitor: pops an expected word for every response, checks hold otherwise.
    always @(negedge clk) begin
        logic [DW-1:0] r;
        logic [DW-1:0] e;
        if (rst) begin
            last[0] = '0;
            last[1] = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r = (i == 0) ? rd0 : rd1;
                if (rv[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        check("rsp_unexpected", 32'(rv[i]), 32'd0);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check((i == 0) ? "rdata_b0" : "rdata_b1", 32'(r), 32'(e));
                    end
                    last[i] = r;
                end else begin
                    check("rdata_hold", 32'(r), 32'(last[i]));
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        bit            v;
        bit            we;
        bit            c;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_rsp_valid", 32'(rv), 32'd0);
        check("rst_rdata0", 32'(rd0), 32'd0);
        check("rst_rdata1", 32'(rd1), 32'd0);
        check("rst_init_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Fill with a read of 0x7F held pending throughout.
        for (int n = 0; n < 600 && !(run[0] && run[1]); n++) rd(8'h7F);
        rd(8'h7F);

        wr(8'h01, 16'hA5C3, 2'b11);
        rd(8'h01);
        rd(8'h00);
        wr(8'h01, 16'hFFFF, 2'b10);
        rd(8'h01);
        wr(8'h02, 16'h1357, 2'b11);
        wr(8'h03, 16'hBEEF, 2'b11);
        rd(8'h01);
        rd(8'h02);
        rd(8'h03);
        idle();

        // Soft clear right after an accepted read, with a write alongside.
        rd(8'h01);
        step(1'b1, 1'b1, 8'h01, 16'h1234, 2'b11, 1'b1);
        wait_run("clr_refill");
        rd(8'h01);

        // Range: only the 200-deep bank drops the write and reads zero.
        wr(8'hF0, 16'h5AA5, 2'b11);
        rd(8'hF0);
        rd(8'hC7);
        rd(8'hC8);

        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 9) != 0);
            we = ($urandom_range(0, 1) == 1);
            a  = AW'($urandom);
            d  = DW'($urandom);
            be = BW'($urandom);
            c  = ($urandom_range(0, 199) == 0);
            step(v, we, a, d, be, c);
        end
        wait_run("rand_refill");

        // Reset during the cycle that carries a read response.
        wr(8'h05, 16'hC0DE, 2'b11);
        rd(8'h05);
        check("rv_before_rst", 32'(rv), 32'd3);
        rst = 1'b1;
        model_reset();
        #1;
        check("rv_after_rst", 32'(rv), 32'd0);
        check("done_after_rst", 32'(done), 32'd0);
        check("rdata_after_rst", 32'(rd0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_run("rst_refill");
        rd(8'h05);
        idle();
        idle();

        check("drain_b0", 32'(q0.size()), 32'd0);
        check("drain_b1", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
